// File: rtl/gameover_overlay_if.sv
// ---------------------------------------------------------------------------
// gameover_overlay_if
//
// Pixel-stream bundle between the video timing/banner ROM side and the
// game-over compositor.
//
// Signals:
//   video_on     : visible-area flag, aligned with the x/y sent to the ROM
//   bg_rgb       : 12-bit background pixel, aligned with video_on
//   gameover_on  : banner opaque flag, one cycle after x/y (synchronous ROM)
//   gameover_rgb : 12-bit banner pixel, same alignment as gameover_on
//   rgb_out      : 12-bit final registered pixel toward the VGA pins
//
// Stream semantics: there is no valid/ready pair on this bundle. Every clock
// carries one pixel, and the compositor cannot stall the raster. video_on
// plays the role of "valid" for bg_rgb. gameover_on/gameover_rgb belong to
// the pixel presented one cycle earlier.
//
// Modports:
//   master : pixel source (timing generator + ROM), reads rgb_out
//   slave  : compositor, drives rgb_out
// ---------------------------------------------------------------------------
interface gameover_overlay_if;
  logic        video_on;
  logic [11:0] bg_rgb;
  logic        gameover_on;
  logic [11:0] gameover_rgb;
  logic [11:0] rgb_out;

  modport master (
    output video_on,
    output bg_rgb,
    output gameover_on,
    output gameover_rgb,
    input  rgb_out
  );

  modport slave (
    input  video_on,
    input  bg_rgb,
    input  gameover_on,
    input  gameover_rgb,
    output rgb_out
  );
endinterface

// File: rtl/gameover_overlay.sv
// ---------------------------------------------------------------------------
// gameover_overlay
//
// Final compositor for the game-over banner. It sequences the banner through
// the blink, hold and rearm phases. It merges the banner over a dimmed or
// plain background and registers the result for the VGA pins. It also raises
// a one-cycle restart request once the player may restart.
//
// Ports:
//   clk           : pixel clock
//   reset_n       : asynchronous active-low reset
//   frame_tick    : one-cycle pulse at start of vertical blank
//   game_over     : level from game logic
//   restart       : debounced one-cycle button pulse
//   pix           : pixel stream bundle (slave side), carries rgb_out
//   restart_req   : one-cycle registered restart request
//   overlay_state : registered FSM state (0 IDLE, 1 BLINK, 2 HOLD, 3 REARM)
//
// Latency: rgb_out reflects the x/y presented two cycles earlier.
// ---------------------------------------------------------------------------
module gameover_overlay #(
  parameter int BLINK_FRAMES    = 30,
  parameter int BLINK_COUNT     = 3,
  parameter int HOLD_MIN_FRAMES = 60,
  parameter int DIM_SHIFT       = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               frame_tick,
  input  logic               game_over,
  input  logic               restart,
  gameover_overlay_if.slave  pix,
  output logic               restart_req,
  output logic [1:0]         overlay_state
);

  // One frame counter serves both BLINK and HOLD, so it is sized for the larger limit.
  localparam int CNT_MAX = (BLINK_FRAMES > HOLD_MIN_FRAMES) ? BLINK_FRAMES : HOLD_MIN_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TOG_MAX = 2 * BLINK_COUNT;
  localparam int TOG_W   = $clog2(TOG_MAX + 1);

  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [CNT_W-1:0] HOLD_SAT   = CNT_W'(HOLD_MIN_FRAMES);
  localparam logic [TOG_W-1:0] TOG_LAST   = TOG_W'(TOG_MAX - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLINK = 2'd1,
    HOLD  = 2'd2,
    REARM = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   frame_cnt;
  logic [TOG_W-1:0]   tog_cnt;
  logic               phase;
  logic               dim_en;
  logic               text_en;
  logic [11:0]        bg_d;
  logic               von_d;
  logic [11:0]        pix_next;

  assign overlay_state = state;

  // Sequencer. Abort (game_over low) takes priority over every other event.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      frame_cnt   <= '0;
      tog_cnt     <= '0;
      phase       <= 1'b1;
      restart_req <= 1'b0;
    end else begin
      restart_req <= 1'b0;
      case (state)
        IDLE: begin
          if (game_over) begin
            state     <= BLINK;
            frame_cnt <= '0;
            tog_cnt   <= '0;
            phase     <= 1'b1;
          end
        end
        BLINK: begin
          if (!game_over) begin
            state <= IDLE;
          end else if (frame_tick) begin
            if (frame_cnt == BLINK_LAST) begin
              frame_cnt <= '0;
              tog_cnt   <= tog_cnt + 1'b1;
              // The last toggle goes straight to HOLD. The banner stays
              // visible, and this tick is not counted toward the hold time.
              if (tog_cnt == TOG_LAST) begin
                state <= HOLD;
                phase <= 1'b1;
              end else begin
                phase <= ~phase;
              end
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (!game_over) begin
            state <= IDLE;
          end else if (restart && (frame_cnt == HOLD_SAT)) begin
            state       <= REARM;
            restart_req <= 1'b1;
          end else if (frame_tick && (frame_cnt != HOLD_SAT)) begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
        REARM: begin
          if (!game_over) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The display mode changes only at vertical blank, so a frame is never
  // drawn half in one mode and half in the other.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dim_en  <= 1'b0;
      text_en <= 1'b0;
    end else if (frame_tick) begin
      dim_en  <= (state != IDLE);
      text_en <= ((state == BLINK) || (state == HOLD)) && phase;
    end
  end

  always_comb begin
    pix_next = bg_d;
    if (!von_d) begin
      pix_next = 12'h000;
    end else if (text_en && pix.gameover_on) begin
      pix_next = pix.gameover_rgb;
    end else if (dim_en) begin
      pix_next = {bg_d[11:8] >> DIM_SHIFT, bg_d[7:4] >> DIM_SHIFT, bg_d[3:0] >> DIM_SHIFT};
    end
  end

  // Stage 1 delays the background so that it lines up with the ROM output.
  // Stage 2 registers the composed pixel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bg_d        <= 12'h000;
      von_d       <= 1'b0;
      pix.rgb_out <= 12'h000;
    end else begin
      bg_d        <= pix.bg_rgb;
      von_d       <= pix.video_on;
      pix.rgb_out <= pix_next;
    end
  end

endmodule

// File: tb/tb_gameover_overlay.sv
// ---------------------------------------------------------------------------
// tb_gameover_overlay
//
// Directed bench for gameover_overlay with a frame-level reference model.
// The model works from tick counts: blink visibility comes from the number of
// ticks since entering BLINK, and the hold time is a saturating tick count.
// It predicts rgb_out, restart_req and overlay_state, and these are compared
// every cycle. Literal expectations at chosen points pin the model.
// ---------------------------------------------------------------------------
module tb_gameover_overlay;
  localparam int BF = 2;
  localparam int BC = 1;
  localparam int HM = 3;
  localparam int DS = 1;
  localparam int FRAME_LEN = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       game_over = 1'b0;
  logic       restart = 1'b0;
  logic       restart_req;
  logic [1:0] overlay_state;

  int checks = 0;
  int failures = 0;

  gameover_overlay_if pix();

  gameover_overlay #(
    .BLINK_FRAMES(BF),
    .BLINK_COUNT(BC),
    .HOLD_MIN_FRAMES(HM),
    .DIM_SHIFT(DS)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .frame_tick(frame_tick),
    .game_over(game_over),
    .restart(restart),
    .pix(pix),
    .restart_req(restart_req),
    .overlay_state(overlay_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] dim12(input logic [11:0] x);
    logic [3:0] r, g, b;
    r = x[11:8] >> DS;
    g = x[7:4] >> DS;
    b = x[3:0] >> DS;
    return {r, g, b};
  endfunction

  // Banner visibility for the frame starting after t counted BLINK ticks.
  function automatic logic blink_visible(input int t);
    return ((t / BF) % 2) == 0;
  endfunction

  // ---------------- reference model + per-cycle compare ----------------
  int          m_state = 0;   // 0 idle, 1 blink, 2 hold, 3 rearm
  int          m_ticks = 0;
  logic        m_text = 1'b0;
  logic        m_dim = 1'b0;
  logic        m_von_d = 1'b0;
  logic        m_req = 1'b0;
  logic [11:0] m_bg_d = 12'h000;
  logic [11:0] m_rgb = 12'h000;
  logic [11:0] m_nrgb;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_state = 0; m_ticks = 0; m_text = 1'b0; m_dim = 1'b0;
      m_von_d = 1'b0; m_req = 1'b0; m_bg_d = 12'h000; m_rgb = 12'h000;
    end else begin
      if (!m_von_d)                         m_nrgb = 12'h000;
      else if (m_text && pix.gameover_on)   m_nrgb = pix.gameover_rgb;
      else if (m_dim)                       m_nrgb = dim12(m_bg_d);
      else                                  m_nrgb = m_bg_d;
      m_rgb   = m_nrgb;
      m_bg_d  = pix.bg_rgb;
      m_von_d = pix.video_on;
      if (frame_tick) begin
        m_dim  = (m_state != 0);
        m_text = ((m_state == 1) && blink_visible(m_ticks)) || (m_state == 2);
      end
      m_req = 1'b0;
      case (m_state)
        0: if (game_over) begin m_state = 1; m_ticks = 0; end
        1: begin
          if (!game_over) m_state = 0;
          else if (frame_tick) begin
            if (m_ticks + 1 == 2 * BC * BF) begin m_state = 2; m_ticks = 0; end
            else m_ticks++;
          end
        end
        2: begin
          if (!game_over) m_state = 0;
          else if (restart && (m_ticks == HM)) begin m_state = 3; m_req = 1'b1; end
          else if (frame_tick && (m_ticks < HM)) m_ticks++;
        end
        default: if (!game_over) m_state = 0;
      endcase
    end
    #1;
    check("model rgb_out", pix.rgb_out, m_rgb);
    check("model restart_req", 12'(restart_req), 12'(m_req));
    check("model overlay_state", 12'(overlay_state), 12'(m_state));
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n, input logic vo);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b0;
      pix.video_on = vo;
      @(posedge clk); #2;
      restart = 1'b0;
    end
  endtask

  task automatic do_frame(input string name, input logic [11:0] exp);
    for (int c = 0; c < FRAME_LEN; c++) begin
      frame_tick = (c == 0);
      pix.video_on = (c >= 4) && (c < 12);
      @(posedge clk); #2;
      if (c == 9)  check({name, " visible"}, pix.rgb_out, exp);
      if (c == 14) check({name, " blank"}, pix.rgb_out, 12'h000);
    end
    frame_tick = 1'b0;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    frame_tick = 1'b0;
    pix.video_on = 1'b0;
    @(posedge clk); #2;
    restart = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    pix.video_on = 1'b0;
    pix.bg_rgb = 12'hABC;
    pix.gameover_on = 1'b1;
    pix.gameover_rgb = 12'hF00;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("reset rgb_out", pix.rgb_out, 12'h000);
    check("reset state", 12'(overlay_state), 12'h000);
    check("reset restart_req", 12'(restart_req), 12'h000);
    reset_n = 1'b1;
    idle(2, 1'b0);

    // pass-through
    do_frame("pass abc", 12'hABC);
    pix.bg_rgb = 12'h3F7;
    do_frame("pass 3f7", 12'h3F7);
    pix.bg_rgb = 12'hABC;
    do_frame("pass abc again", 12'hABC);

    // enter BLINK mid-frame: mode must not change before the next tick
    game_over = 1'b1;
    idle(8, 1'b1);
    check("tear rgb_out", pix.rgb_out, 12'hABC);
    check("tear state", 12'(overlay_state), 12'h001);

    // blink sequence
    do_frame("blink f1", 12'hF00);
    do_frame("blink f2", 12'hF00);
    do_frame("blink f3", 12'h556);
    do_frame("blink f4", 12'h556);
    check("hold entered", 12'(overlay_state), 12'h002);
    do_frame("hold f5", 12'hF00);

    // early restart is ignored
    pulse_restart();
    check("early restart state", 12'(overlay_state), 12'h002);
    check("early restart req", 12'(restart_req), 12'h000);
    do_frame("hold f6", 12'hF00);
    do_frame("hold f7", 12'hF00);
    pulse_restart();
    check("restart state", 12'(overlay_state), 12'h003);
    check("restart req high", 12'(restart_req), 12'h001);
    idle(1, 1'b0);
    check("restart req drop", 12'(restart_req), 12'h000);

    // rearm: stays while game_over is high
    for (int f = 0; f < 10; f++) do_frame("rearm", 12'h556);
    check("rearm state", 12'(overlay_state), 12'h003);
    game_over = 1'b0;
    idle(1, 1'b0);
    check("rearm to idle", 12'(overlay_state), 12'h000);
    do_frame("idle pass", 12'hABC);

    // abort in HOLD together with restart
    game_over = 1'b1;
    idle(1, 1'b0);
    do_frame("b2 f1", 12'hF00);
    do_frame("b2 f2", 12'hF00);
    do_frame("b2 f3", 12'h556);
    do_frame("b2 f4", 12'h556);
    for (int f = 0; f < 3; f++) do_frame("b2 hold", 12'hF00);
    game_over = 1'b0;
    restart = 1'b1;
    idle(1, 1'b0);
    check("abort state", 12'(overlay_state), 12'h000);
    check("abort req", 12'(restart_req), 12'h000);

    // asynchronous reset during BLINK
    game_over = 1'b1;
    idle(1, 1'b0);
    do_frame("b3 f1", 12'hF00);
    idle(5, 1'b1);
    check("pre reset rgb_out", pix.rgb_out, 12'hF00);
    reset_n = 1'b0;
    #1;
    check("async reset rgb_out", pix.rgb_out, 12'h000);
    check("async reset state", 12'(overlay_state), 12'h000);
    check("async reset req", 12'(restart_req), 12'h000);
    game_over = 1'b0;
    idle(2, 1'b1);
    reset_n = 1'b1;
    idle(3, 1'b1);
    do_frame("post reset pass", 12'hABC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gameover_overlay.md
# gameover_overlay

Downstream compositor for the game-over banner. Consumes the banner pixel stream (`gameover_on`, `gameover_rgb`) and the already-composited background pixel. Sequences the banner through blink, hold and restart phases, then emits the final registered pixel to the VGA output pins. It also generates the restart request back to game logic.

## Interface
Parameters:
- `BLINK_FRAMES`, 30: frames per blink half-period.
- `BLINK_COUNT`, 3: full on/off blink cycles before HOLD.
- `HOLD_MIN_FRAMES`, 60: frames in HOLD before restart is accepted; must be ≥1.
- `DIM_SHIFT`, 1: right-shift applied to each 4-bit background channel while dimmed.

Ports:
- `clk` in 1: pixel clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `video_on` in 1: visible-area flag, aligned with the x/y presented to the banner ROM.
- `frame_tick` in 1: one-cycle pulse at start of vertical blank, once per frame.
- `game_over` in 1: level from game logic.
- `restart` in 1: debounced one-cycle button pulse.
- `bg_rgb` in 12: background pixel, aligned with `video_on`.
- `gameover_on` in 1: banner opaque flag, one cycle after x/y (synchronous ROM).
- `gameover_rgb` in 12: banner pixel, same alignment as `gameover_on`.
- `rgb_out` out 12: final registered pixel.
- `restart_req` out 1: one-cycle registered pulse.
- `overlay_state` out 2: current FSM state, for debug/LED.

## Operation
- FSM states:
  - IDLE=0
  - BLINK=1
  - HOLD=2
  - REARM=3
- IDLE → BLINK when `game_over`=1. On entry: frame counter=0, `phase`=1 (visible), toggle counter=0.
- BLINK:
  - Each `frame_tick` increments the frame counter.
  - On the tick where the counter equals `BLINK_FRAMES`-1: toggle `phase`, clear the counter, increment the toggle counter.
  - When the toggle counter reaches 2·`BLINK_COUNT`: go to HOLD, with `phase`=1 and the frame counter cleared.
- HOLD:
  - The frame counter increments on `frame_tick` and saturates at `HOLD_MIN_FRAMES`.
  - `restart`=1 with counter=`HOLD_MIN_FRAMES` → REARM, and `restart_req`=1 on the next cycle for exactly one cycle.
  - `restart` at any earlier point is ignored.
- REARM → IDLE when `game_over`=0.
- Abort: `game_over`=0 while in BLINK or HOLD → IDLE next cycle.
- `restart` in IDLE, BLINK or REARM has no effect.
- Display mode is latched only on `frame_tick`, so there is no mid-frame tearing:
  - `dim_en` = (state≠IDLE)
  - `text_en` = (state∈{BLINK,HOLD}) ∧ `phase`
- Pixel composition, stage 2, using stage-1 delayed `bg_rgb_d`/`video_on_d`, in priority order:
  1. `video_on_d`=0 → 0.
  2. Else `text_en` ∧ `gameover_on` → `gameover_rgb`.
  3. Else `dim_en` → each 4-bit channel of `bg_rgb_d` >> `DIM_SHIFT`.
  4. Else → `bg_rgb_d`.

## Timing
- Latency: `rgb_out` reflects the x/y that was presented 2 cycles earlier.
  - `bg_rgb`/`video_on` are delayed 1 cycle to meet the ROM output, then registered again.
- Reset (async, `reset_n`=0), all outputs and registers clear immediately:
  - `rgb_out`=0
  - `restart_req`=0
  - `overlay_state`=0
  - counters=0
  - `phase`=1
  - `dim_en`=`text_en`=0
  - delay registers 0
- Reset mid-sequence returns to IDLE with no `restart_req`.
- FSM transitions take effect the cycle after their condition is sampled.
- `overlay_state` is the registered state.
- Simultaneous `frame_tick` with a BLINK→HOLD transition: the HOLD counter starts at 0. That tick is not counted.
- Simultaneous `game_over` fall and `restart` in HOLD: abort wins → IDLE, no pulse.
- Counters are sized ⌈log2(max+1)⌉ and never wrap: HOLD saturates, BLINK clears.

## Test plan
Bench parameters: BLINK_FRAMES=2, BLINK_COUNT=1, HOLD_MIN_FRAMES=3, DIM_SHIFT=1.

1. **Pass-through.** Reset, then `game_over`=0, `bg_rgb`=0xABC, `video_on`=1 → `rgb_out`=0xABC two cycles later. `video_on`=0 → 0x000.
2. **Blink sequence.** Assert `game_over`, hold `gameover_on`=1, `gameover_rgb`=0xF00.
   - Output sequence per frame: 0xF00 for frames 1–2, dimmed 0x556 (from 0xABC) for frames 3–4.
   - `overlay_state`=2 after the 4th tick, with steady 0xF00.
3. **Early restart.** In HOLD, pulse `restart` after 1 tick → ignored, state stays 2. After 3 ticks, pulse `restart` → state 3 and `restart_req` high exactly 1 cycle.
4. **Rearm.** From REARM, hold `game_over`=1 for 10 frames → stays 3, no further pulse. Drop it → IDLE, output pass-through at the next `frame_tick`.
5. **Tearing.** Enter BLINK mid-frame → `rgb_out` unchanged until the next `frame_tick`.
6. **Abort and reset.** Drop `game_over` during HOLD at the same time as `restart` → IDLE, no `restart_req`. Assert `reset_n`=0 during BLINK → all outputs 0 immediately.
